// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg -- shared definitions for the LCD read/write controllers.
//   lcd_state_e        : read/write cycle phases (IDLE, SETUP, EN_HI, HOLD)
//   LCD_RS_CMD/DATA    : register-select encodings
//   LCD_*_DEF          : default bus timing in clock cycles
//   LCD_BF_BIT         : position of the busy flag in a status read
//   phase_limit()      : converts a cycle count into a terminal-count value
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EN_HI = 2'd2,
    HOLD  = 2'd3
  } lcd_state_e;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  localparam int LCD_CLK_DIVIDE_DEF = 16;
  localparam int LCD_SETUP_DEF      = 1;
  localparam int LCD_HOLD_DEF       = 2;

  localparam int LCD_BF_BIT = 7;

  // A phase lasting cyc cycles ends when the counter reaches cyc-1.
  function automatic logic [7:0] phase_limit(input int cyc);
    return 8'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_phase_counter.sv
// ---------------------------------------------------------------------------
// lcd_phase_counter -- 8-bit phase counter with clear, enable and a
// terminal-count compare against a runtime limit.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_clear : return count to 0 (has priority over i_en)
//   i_en    : advance count by one
//   i_limit : terminal value
//   o_tc    : high while count == i_limit
// The owner clears the counter on o_tc, so it never wraps within a phase.
// ---------------------------------------------------------------------------
module lcd_phase_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [7:0] i_limit,
  output logic       o_tc
);

  logic [7:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/lcd_reader.sv
// ---------------------------------------------------------------------------
// lcd_reader -- performs one HD44780-style read cycle (LCD_RW=1) per rising
// edge of iStart. iRS=0 reads busy flag + address counter, iRS=1 reads data.
//   iCLK, iRST        : clock, synchronous active-high reset
//   iStart, iRS       : start request (rising edge), register select
//   oDATA, oBF, oADDR : last sampled byte, and its bit 7 / bits 6:0 slices
//   oDone             : level, set on completion, cleared on next acceptance
//   oBusOwn           : high from acceptance to completion (bus granted)
//   LCD_DATA          : pad-side data bus input
//   LCD_RW/EN/RS      : LCD control lines
// Optional macro LCD_READER_BF_POLL_EN: adds POLL_MAX and oTimeout; a status
// read returning BF=1 is repeated (bus kept) until BF=0 or POLL_MAX reads.
// ---------------------------------------------------------------------------
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int CLK_Divide = LCD_CLK_DIVIDE_DEF,
  parameter int SETUP_CYC  = LCD_SETUP_DEF,
  parameter int HOLD_CYC   = LCD_HOLD_DEF
`ifdef LCD_READER_BF_POLL_EN
  , parameter int POLL_MAX = 255
`endif
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  output logic [7:0] oDATA,
  output logic       oBF,
  output logic [6:0] oADDR,
  output logic       oDone,
  output logic       oBusOwn,
`ifdef LCD_READER_BF_POLL_EN
  output logic       oTimeout,
`endif
  input  logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  lcd_state_e r_state;
  lcd_state_e w_next_state;
  logic       r_pre_start;
  logic       w_accept;
  logic [7:0] w_limit;
  logic       w_tc;
  logic       w_poll_again;

  // Only a fresh rising edge seen while idle starts a read; nothing queues.
  assign w_accept = ~r_pre_start & iStart & (r_state == IDLE);

  // Phase length selection for the shared counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_limit = 8'd0;
    case (r_state)
      SETUP:   w_limit = phase_limit(SETUP_CYC);
      EN_HI:   w_limit = phase_limit(CLK_Divide);
      HOLD:    w_limit = phase_limit(HOLD_CYC);
      default: w_limit = 8'd0;
    endcase
  end

  // Counter runs only inside a read; held at 0 while idle and restarted at
  // each phase boundary.
  lcd_phase_counter u_phase_counter (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_clear ((r_state == IDLE) | w_tc),
    .i_en    (r_state != IDLE),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

`ifdef LCD_READER_BF_POLL_EN
  logic [7:0] r_polls;
  // LCD_RS holds the latched RS for the whole read, and oDATA already holds
  // this read's sample by the time HOLD ends.
  assign w_poll_again = (LCD_RS == LCD_RS_CMD) && oDATA[LCD_BF_BIT] &&
                        (r_polls != 8'(POLL_MAX - 1));
`else
  assign w_poll_again = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SETUP;
      SETUP:   if (w_tc)     w_next_state = EN_HI;
      EN_HI:   if (w_tc)     w_next_state = HOLD;
      HOLD:    if (w_tc)     w_next_state = w_poll_again ? SETUP : IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_pre_start <= 1'b0;
      oDATA       <= 8'd0;
      oDone       <= 1'b0;
      oBusOwn     <= 1'b0;
      LCD_RW      <= 1'b0;
      LCD_EN      <= 1'b0;
      LCD_RS      <= 1'b0;
`ifdef LCD_READER_BF_POLL_EN
      oTimeout    <= 1'b0;
      r_polls     <= 8'd0;
`endif
    end else begin
      r_pre_start <= iStart;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            oDone   <= 1'b0;
            oBusOwn <= 1'b1;
            LCD_RW  <= 1'b1;
            LCD_RS  <= iRS;
`ifdef LCD_READER_BF_POLL_EN
            oTimeout <= 1'b0;
            r_polls  <= 8'd0;
`endif
          end
        end
        SETUP: begin
          if (w_tc) LCD_EN <= 1'b1;
        end
        EN_HI: begin
          // Sample on the last enable cycle, when the LCD output is settled.
          if (w_tc) begin
            LCD_EN <= 1'b0;
            oDATA  <= LCD_DATA;
          end
        end
        HOLD: begin
          if (w_tc) begin
            if (w_poll_again) begin
`ifdef LCD_READER_BF_POLL_EN
              r_polls <= r_polls + 8'd1;
`endif
            end else begin
              oDone   <= 1'b1;
              oBusOwn <= 1'b0;
              LCD_RW  <= 1'b0;
              LCD_RS  <= 1'b0;
`ifdef LCD_READER_BF_POLL_EN
              // Finishing a status read with BF still set means we ran out.
              oTimeout <= (LCD_RS == LCD_RS_CMD) && oDATA[LCD_BF_BIT];
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign oBF   = oDATA[LCD_BF_BIT];
  assign oADDR = oDATA[6:0];

endmodule
